// File: rtl/dram_burst_responder_pkg.sv
// Shared types and helpers for the DRAM refill responder.
// Holds the FSM state encoding and line-address arithmetic.
package mem_if_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LAT,
        BURST,
        DONE
    } state_e;

    localparam int unsigned LINE_WORDS         = 8;
    localparam int unsigned LINE_BYTE_OFFSET_W = 5;

    // Byte address -> word address of the first word in its cache line.
    function automatic logic [31:0] line_word_base(input logic [31:0] addr);
        logic [31:0] w;
        w = addr >> 2;
        w[LINE_BYTE_OFFSET_W-3:0] = '0;
        return w;
    endfunction

endpackage

// File: rtl/dram_burst_responder_if.sv
// Cache-to-DRAM refill handshake: request/address in, burst data out.
interface dram_burst_responder_if;

    logic        dram_req;
    logic [31:0] dram_req_addr;
    logic [31:0] dram_data;
    logic        dram_val;

    modport master (
        output dram_req,
        output dram_req_addr,
        input  dram_data,
        input  dram_val
    );

    modport slave (
        input  dram_req,
        input  dram_req_addr,
        output dram_data,
        output dram_val
    );

endinterface

// File: rtl/dram_burst_responder_mem.sv
// Word-addressed backing array: one write port, one registered read port.
// A read and a write to the same word at the same edge return the old value.
module burst_mem_array #(
  parameter int unsigned ADDR_W    = 12,
  parameter              INIT_FILE = ""
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [31:0]       rd_data,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [31:0]       wr_data
);

  logic [31:0] mem [2**ADDR_W];

  initial begin
    for (int unsigned i = 0; i < 2**ADDR_W; i++) begin
      mem[i] = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Read register doubles as the output data register; it holds between beats.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/dram_burst_responder.sv
// DRAM stand-in for icache refills: accepts a line request, waits LATENCY
// cycles, then streams BLOCK_SIZE ascending words, one per cycle.
module dram_burst_responder
    import mem_if_pkg::*;
#(
    parameter int unsigned BLOCK_SIZE = LINE_WORDS,
    parameter int unsigned LATENCY    = 4,
    parameter int unsigned ADDR_W     = 12,
    parameter              INIT_FILE  = ""
) (
    input  logic                    clk,
    input  logic                    reset_n,
    dram_burst_responder_if.slave   dram,
    output logic                    busy,
    input  logic                    prog_we,
    input  logic [ADDR_W-1:0]       prog_addr,
    input  logic [31:0]             prog_wdata
);

    localparam int unsigned BEAT_W = $clog2(BLOCK_SIZE);
    localparam int unsigned LAT_W  = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [LAT_W-1:0]  LAT_LOAD  = LAT_W'((LATENCY > 0) ? LATENCY - 1 : 0);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BLOCK_SIZE - 1);

    state_e              state, state_n;
    logic [LAT_W-1:0]    lat_cnt, lat_n;
    logic [BEAT_W-1:0]   beat_cnt, beat_n;
    logic [ADDR_W-1:0]   base, base_n;
    logic                rd_en;
    logic [ADDR_W-1:0]   rd_addr;
    logic [31:0]         rd_data;
    logic                val_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            lat_cnt  <= '0;
            beat_cnt <= '0;
            base     <= '0;
            val_q    <= 1'b0;
        end else begin
            state    <= state_n;
            lat_cnt  <= lat_n;
            beat_cnt <= beat_n;
            base     <= base_n;
            val_q    <= rd_en;
        end
    end

    always_comb begin
        state_n = state;
        lat_n   = lat_cnt;
        beat_n  = beat_cnt;
        base_n  = base;
        rd_en   = 1'b0;
        case (state)
            IDLE: begin
                if (dram.dram_req) begin
                    base_n = ADDR_W'(line_word_base(dram.dram_req_addr));
                    beat_n = '0;
                    if (LATENCY > 0) begin
                        state_n = LAT;
                        lat_n   = LAT_LOAD;
                    end else begin
                        state_n = BURST;
                    end
                end
            end
            LAT: begin
                if (lat_cnt == '0) begin
                    state_n = BURST;
                end else begin
                    lat_n = lat_cnt - 1'b1;
                end
            end
            // Each edge seen in BURST launches one beat; dram_req is not looked at.
            BURST: begin
                rd_en = 1'b1;
                if (beat_cnt == LAST_BEAT) begin
                    state_n = DONE;
                    beat_n  = '0;
                end else begin
                    beat_n = beat_cnt + 1'b1;
                end
            end
            DONE: begin
                if (!dram.dram_req) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign rd_addr = base + ADDR_W'(beat_cnt);

    burst_mem_array #(
        .ADDR_W   (ADDR_W),
        .INIT_FILE(INIT_FILE)
    ) u_mem (
        .clk    (clk),
        .reset_n(reset_n),
        .rd_en  (rd_en),
        .rd_addr(rd_addr),
        .rd_data(rd_data),
        .wr_en  (prog_we),
        .wr_addr(prog_addr),
        .wr_data(prog_wdata)
    );

    assign dram.dram_data = rd_data;
    assign dram.dram_val  = val_q;
    assign busy           = (state != IDLE);

endmodule

// File: tb/tb_dram_burst_responder.sv
// Randomized bench for dram_burst_responder: a LATENCY=4 and a LATENCY=0
// instance share stimulus and are compared to a line-level memory model.
module tb_dram_burst_responder;

    localparam int unsigned ADDR_W   = 12;
    localparam int unsigned DEPTH    = 1 << ADDR_W;
    localparam int unsigned BLK      = 8;
    localparam int          LAT_SLOW = 4;

    logic              clk        = 1'b0;
    logic              reset_n    = 1'b1;
    logic              req        = 1'b0;
    logic [31:0]       req_addr   = '0;
    logic              prog_we    = 1'b0;
    logic [ADDR_W-1:0] prog_addr  = '0;
    logic [31:0]       prog_wdata = '0;
    logic              busy4, busy0;

    always #5 clk = ~clk;

    dram_burst_responder_if if4();
    dram_burst_responder_if if0();

    assign if4.dram_req      = req;
    assign if4.dram_req_addr = req_addr;
    assign if0.dram_req      = req;
    assign if0.dram_req_addr = req_addr;

    dram_burst_responder #(
        .BLOCK_SIZE(8), .LATENCY(4), .ADDR_W(12), .INIT_FILE("")
    ) u_dut4 (
        .clk(clk), .reset_n(reset_n), .dram(if4), .busy(busy4),
        .prog_we(prog_we), .prog_addr(prog_addr), .prog_wdata(prog_wdata)
    );

    dram_burst_responder #(
        .BLOCK_SIZE(8), .LATENCY(0), .ADDR_W(12), .INIT_FILE("")
    ) u_dut0 (
        .clk(clk), .reset_n(reset_n), .dram(if0), .busy(busy0),
        .prog_we(prog_we), .prog_addr(prog_addr), .prog_wdata(prog_wdata)
    );

    logic        dval  [2];
    logic [31:0] ddata [2];
    logic        dbusy [2];
    assign dval[0]  = if4.dram_val;
    assign dval[1]  = if0.dram_val;
    assign ddata[0] = if4.dram_data;
    assign ddata[1] = if0.dram_data;
    assign dbusy[0] = busy4;
    assign dbusy[1] = busy0;

    logic [31:0] model     [DEPTH];
    logic [31:0] last_data [2];
    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic int line_base(input logic [31:0] addr);
        return int'(((addr / 4) / BLK * BLK) % DEPTH);
    endfunction

    // Cache behaviour: hold the request until the slow responder's last beat
    // plus `hold` cycles, optionally dropping it early after edge `drop`.
    function automatic logic req_for_edge(input int e, input int hold, input int drop);
        return (e <= LAT_SLOW + int'(BLK) + hold) && !(drop > 0 && e > drop);
    endfunction

    task automatic run_req(input logic [31:0] addr, input int hold, input int drop,
                           input int wr_k, input logic [ADDR_W-1:0] wr_idx,
                           input logic [31:0] wr_val);
        int base;
        int f [2];
        int lat;
        bit exp_val;
        base = line_base(addr);
        for (int d = 0; d < 2; d++) begin
            lat  = (d == 0) ? LAT_SLOW : 0;
            f[d] = lat + int'(BLK) + 1;
            while (req_for_edge(f[d], hold, drop)) f[d]++;
        end
        req_addr = addr;
        for (int k = 0; k < 20; k++) begin
            req = req_for_edge(k, hold, drop);
            if (k == wr_k) begin
                prog_we    = 1'b1;
                prog_addr  = wr_idx;
                prog_wdata = wr_val;
            end
            @(negedge clk);
            prog_we  = 1'b0;
            req_addr = $urandom();
            for (int d = 0; d < 2; d++) begin
                lat     = (d == 0) ? LAT_SLOW : 0;
                exp_val = (k >= lat + 1) && (k <= lat + int'(BLK));
                if (exp_val) last_data[d] = model[(base + k - lat - 1) % DEPTH];
                check_eq($sformatf("L%0d a%08h e%0d val", lat, addr, k), 32'(dval[d]), 32'(exp_val));
                check_eq($sformatf("L%0d a%08h e%0d data", lat, addr, k), ddata[d], last_data[d]);
                check_eq($sformatf("L%0d a%08h e%0d busy", lat, addr, k), 32'(dbusy[d]), 32'(k < f[d]));
            end
            if (k == wr_k) model[wr_idx] = wr_val;
        end
    endtask

    task automatic reset_mid_burst(input logic [31:0] addr, input logic [31:0] addr2);
        req_addr = addr;
        req      = 1'b1;
        for (int k = 0; k <= 8; k++) @(negedge clk);
        check_eq("pre-reset val", 32'(dval[0]), 32'd1);
        reset_n = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
            check_eq($sformatf("rst%0d val", d), 32'(dval[d]), 32'd0);
            check_eq($sformatf("rst%0d data", d), ddata[d], 32'd0);
            check_eq($sformatf("rst%0d busy", d), 32'(dbusy[d]), 32'd0);
            last_data[d] = '0;
        end
        @(negedge clk);
        reset_n = 1'b1;
        run_req(addr2, 1, -1, -1, '0, '0);
    endtask

    initial begin
        logic [31:0]       r_addr;
        int                r_hold, r_drop, r_wk;
        logic [ADDR_W-1:0] r_widx;
        logic [31:0]       r_wval;

        #2 reset_n = 1'b0;
        repeat (2) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            check_eq($sformatf("reset%0d val", d), 32'(dval[d]), 32'd0);
            check_eq($sformatf("reset%0d data", d), ddata[d], 32'd0);
            check_eq($sformatf("reset%0d busy", d), 32'(dbusy[d]), 32'd0);
            last_data[d] = '0;
        end
        reset_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < int'(DEPTH); i++) begin
            prog_we    = 1'b1;
            prog_addr  = ADDR_W'(i);
            prog_wdata = (i >= 'h100 && i < 'h108) ? 32'hA000_0000 + 32'(i - 'h100) : $urandom();
            model[i]   = prog_wdata;
            @(negedge clk);
        end
        prog_we = 1'b0;
        @(negedge clk);

        run_req(32'h0000_0400, 2, -1, -1, '0, '0);
        run_req(32'h0000_0400, 1, -1, -1, '0, '0);
        run_req(32'h0000_3FE0, 1, -1, -1, '0, '0);
        run_req(32'h0001_0000, 2, -1, -1, '0, '0);
        run_req(32'h0000_0400, 1, 6, -1, '0, '0);
        run_req(32'h0000_0400, 1, -1, 8, 12'h105, 32'hDEAD_BEEF);
        run_req(32'h0000_0400, 1, -1, 11, 12'h105, 32'h1234_5678);
        run_req(32'h0000_0400, 1, -1, -1, '0, '0);
        reset_mid_burst(32'h0000_0800, 32'h0000_0420);

        for (int n = 0; n < 24; n++) begin
            r_addr = $urandom();
            r_hold = int'($urandom_range(1, 2));
            r_drop = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 14)) : -1;
            r_wk   = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 14)) : -1;
            r_widx = ADDR_W'(line_base(r_addr) + int'($urandom_range(0, 7)));
            r_wval = $urandom();
            run_req(r_addr, r_hold, r_drop, r_wk, r_widx, r_wval);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
